data_memory_responder: RTL and testbench
========================================

// Module: data_memory_responder
// PURPOSE
//   Responder end of the memory request interface driven by the MEM stage.
//   Word-addressed data RAM: accepts read/write requests, serves them after a
//   programmable wait, signals completion with a ready pulse.
//   Recognises the halt sentinel, optionally streams a memory dump, then parks halted.
// PARAMETERS
//   ADDR_WIDTH  10  word-index width; memory depth = 2**ADDR_WIDTH words
//   LATENCY     2   wait cycles in ACCESS before response (0..15)
// PORTS
//   clock           in   1   rising-edge clock
//   reset           in   1   asynchronous, active-low reset
//   i_memoryWrite   in   1   1 = write, 0 = read (valid only when i_readOrWrite=1)
//   i_readOrWrite   in   1   request present
//   i_memAddress    in   32  byte address
//   i_memData       in   32  write data
//   o_readData      out  32  read data; held until next read response
//   o_ready         out  1   one-cycle completion pulse
//   o_busy          out  1   1 in every state except IDLE
//   o_error         out  1   with o_ready: request was misaligned or out of range
//   o_halted        out  1   sentinel processed; sticky until reset
//   o_dumpValid     out  1   dump beat valid
//   o_dumpAddr      out  32  byte address of dump beat
//   o_dumpData      out  32  word of dump beat
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, counter=0, all outputs 0. RAM contents
//   are not cleared. Reset mid-ACCESS aborts the request; a pending write is not committed.
// - FSM states: IDLE, ACCESS, RESPOND, DUMP, HALT.
// - IDLE: when i_readOrWrite=1, latch write flag, address and data.
//   Sentinel: write=0 and address=32'hFFFF_FFFF -> DUMP.
//   Any other request -> ACCESS with counter=0.
// - ACCESS: counter increments each cycle; at counter==LATENCY -> RESPOND.
//   Commit happens on that transition edge:
//   - write: RAM[idx] <= data;
//   - read: o_readData <= RAM[idx].
//   Acceptance to o_ready = LATENCY+2 cycles (LATENCY=0 -> 2 cycles).
// - Index decode: idx = addr[ADDR_WIDTH+1:2].
//   Error if addr[1:0]!=0 or addr[31:ADDR_WIDTH+2]!=0.
//   On error: no RAM write, o_readData <= 0, o_error=1 during RESPOND.
// - RESPOND: o_ready=1 for exactly one cycle -> IDLE.
//   The requester must drop or change its request the cycle after o_ready.
//   A request still asserted in IDLE is treated as a new request.
// - Inputs are sampled only in IDLE; changes during ACCESS or RESPOND are ignored.
// - HALT: o_halted=1, o_busy=1, requests ignored; exit only via reset.
// - Sentinel with i_memoryWrite=1 is an ordinary write to address FFFF_FFFF,
//   which is out of range -> error response.
// CONFIGURATION
//   MEM_DUMP_EN defined:
//   - DUMP walks idx 0..2**ADDR_WIDTH-1, one beat per cycle.
//   - o_dumpValid=1, o_dumpAddr=idx<<2, o_dumpData=RAM[idx].
//   - After the last beat -> HALT.
//   - Dump length = 2**ADDR_WIDTH cycles; no backpressure.
//   MEM_DUMP_EN undefined:
//   - DUMP lasts one cycle with dump outputs 0, then HALT.
//   - o_dumpValid, o_dumpAddr and o_dumpData are tied to 0 throughout.
//   Both builds:
//   - o_halted rises on entry to HALT.
//   - No o_ready is issued for the sentinel.
// TESTING
// 1. Reset low mid-ACCESS of a write 0x10<-0xDEAD_BEEF, release, read 0x10
//    -> 0x0000_0000 returned (assuming zero-initialised RAM); outputs 0 during reset.
// 2. LATENCY=2: write 0x40<-0x1234_5678, then read 0x40
//    -> o_ready 4 cycles after each acceptance, o_readData=0x1234_5678, o_error=0.
// 3. Read 0x42 (misaligned), then write 0x1000 with ADDR_WIDTH=10
//    -> o_error=1 with o_ready for both; RAM unchanged; o_readData=0.
// 4. Request held across o_ready
//    -> re-accepted on next IDLE cycle; o_busy low exactly one cycle between responses.
// 5. MEM_DUMP_EN, ADDR_WIDTH=4, words 0..15 = idx*3, then read FFFF_FFFF
//    -> 16 consecutive beats with addr 0x00..0x3C, data 0..45;
//       o_halted=1 after the last beat; later requests get no o_ready.
// 6. No MEM_DUMP_EN: sentinel -> o_dumpValid never asserted;
//    o_halted=1 two cycles after acceptance; reset clears o_halted.

Source files
------------

// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data memory
// responder (slave), including the optional memory-dump stream.
interface data_memory_responder_if;
    logic        i_memoryWrite;
    logic        i_readOrWrite;
    logic [31:0] i_memAddress;
    logic [31:0] i_memData;
    logic [31:0] o_readData;
    logic        o_ready;
    logic        o_busy;
    logic        o_error;
    logic        o_halted;
    logic        o_dumpValid;
    logic [31:0] o_dumpAddr;
    logic [31:0] o_dumpData;

    modport master (
        output i_memoryWrite, i_readOrWrite, i_memAddress, i_memData,
        input  o_readData, o_ready, o_busy, o_error, o_halted,
               o_dumpValid, o_dumpAddr, o_dumpData
    );

    modport slave (
        input  i_memoryWrite, i_readOrWrite, i_memAddress, i_memData,
        output o_readData, o_ready, o_busy, o_error, o_halted,
               o_dumpValid, o_dumpAddr, o_dumpData
    );
endinterface

// File: rtl/data_memory_responder.sv
// Word-addressed data RAM responder with programmable wait, halt sentinel and
// an optional post-halt memory dump enabled by defining MEM_DUMP_EN.
module data_memory_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input logic                    clock,
    input logic                    reset,
    data_memory_responder_if.slave mem
);

    localparam int          DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [3:0]  LAT      = 4'(LATENCY);
    localparam logic [31:0] SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        RESPOND,
        DUMP,
        HALT
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  write_q, write_d;
    logic [31:0]           addr_q, addr_d;
    logic [31:0]           data_q, data_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           mem_q [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  addr_err;
    logic                  commit;

    assign idx      = addr_q[ADDR_WIDTH+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
    assign commit   = (state_q == ACCESS) && (cnt_q == LAT);

`ifdef MEM_DUMP_EN
    logic [ADDR_WIDTH-1:0] dump_idx_q, dump_idx_d;
    logic                  dump_last;

    assign dump_last = &dump_idx_q;
`endif

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem.i_readOrWrite) begin
                    if (!mem.i_memoryWrite && (mem.i_memAddress == SENTINEL)) begin
                        state_d = DUMP;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == LAT) begin
                    state_d = RESPOND;
                end
            end
            RESPOND: state_d = IDLE;
`ifdef MEM_DUMP_EN
            DUMP: begin
                if (dump_last) begin
                    state_d = HALT;
                end
            end
`else
            DUMP: state_d = HALT;
`endif
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    // Request capture, wait counter and read-data register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: non-blocking for all sequential state so every flop sees pre-edge values.
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef MEM_DUMP_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dump_idx_q <= '0;
        end else begin
            dump_idx_q <= dump_idx_d;
        end
    end
`endif

    // Datapath next values; RAM write and read capture happen only on the
    // ACCESS -> RESPOND edge, so an aborting reset never commits a write.
    always_comb begin
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        data_d  = data_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef MEM_DUMP_EN
        dump_idx_d = dump_idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (mem.i_readOrWrite) begin
                    write_d = mem.i_memoryWrite;
                    addr_d  = mem.i_memAddress;
                    data_d  = mem.i_memData;
                    cnt_d   = '0;
`ifdef MEM_DUMP_EN
                    dump_idx_d = '0;
`endif
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 4'd1;
                if (commit) begin
                    if (write_q) begin
                        mem_we = !addr_err;
                    end else begin
                        rdata_d = addr_err ? 32'd0 : mem_q[idx];
                    end
                end
            end
`ifdef MEM_DUMP_EN
            DUMP: dump_idx_d = dump_idx_q + ADDR_WIDTH'(1);
`endif
            default: ;
        endcase
    end

    // NOTE: the RAM array has no reset; contents survive reset by design.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem_q[idx] <= data_q;
        end
    end

    // Outputs decoded from the current state.
    always_comb begin
        mem.o_ready    = (state_q == RESPOND);
        mem.o_busy     = (state_q != IDLE);
        mem.o_error    = (state_q == RESPOND) && addr_err;
        mem.o_halted   = (state_q == HALT);
        mem.o_readData = rdata_q;
`ifdef MEM_DUMP_EN
        mem.o_dumpValid = (state_q == DUMP);
        mem.o_dumpAddr  = '0;
        mem.o_dumpData  = '0;
        if (state_q == DUMP) begin
            mem.o_dumpAddr = {{(30 - ADDR_WIDTH){1'b0}}, dump_idx_q, 2'b00};
            mem.o_dumpData = mem_q[dump_idx_q];
        end
`else
        mem.o_dumpValid = 1'b0;
        mem.o_dumpAddr  = '0;
        mem.o_dumpData  = '0;
`endif
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder: directed scenarios plus
// randomized traffic against an array-based memory model.
module tb_data_memory_responder;

    localparam int AW       = 6;
    localparam int LAT      = 2;
    localparam int DEPTH    = 1 << AW;
    localparam int RESP_LAT = LAT + 2;

    logic clock = 1'b0;
    logic reset = 1'b0;

    data_memory_responder_if mem ();

    data_memory_responder #(
        .ADDR_WIDTH(AW),
        .LATENCY   (LAT)
    ) dut (
        .clock(clock),
        .reset(reset),
        .mem  (mem)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] model_mem [DEPTH];
    bit          known     [DEPTH];
    logic [31:0] model_rd = 32'd0;

    function automatic bit exp_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> (AW + 2)) != 32'd0);
    endfunction

    // Applies one completed request to the model and returns expected response.
    function automatic void model_step(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                       output bit e_err, output logic [31:0] e_rd);
        int i;
        i     = int'(addr[AW+1:2]);
        e_err = exp_err(addr);
        if (wr) begin
            if (!e_err) begin
                model_mem[i] = data;
                known[i]     = 1'b1;
            end
        end else begin
            model_rd = e_err ? 32'd0 : model_mem[i];
        end
        e_rd = model_rd;
    endfunction

    // Issues one request from IDLE and returns edges-to-ready (-1 on timeout).
    task automatic transact(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                            output int lat, output logic err, output logic [31:0] rd);
        @(negedge clock);
        mem.i_memoryWrite = wr;
        mem.i_readOrWrite = 1'b1;
        mem.i_memAddress  = addr;
        mem.i_memData     = data;
        lat = -1;
        err = 1'bx;
        rd  = 'x;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            mem.i_readOrWrite = 1'b0;
            if (mem.o_ready === 1'b1) begin
                lat = c;
                err = mem.o_error;
                rd  = mem.o_readData;
                break;
            end
        end
        @(posedge clock);
    endtask

    task automatic test_reset;
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          e_err;
        logic [31:0] e_rd;
        mem.i_memoryWrite = 1'b0;
        mem.i_readOrWrite = 1'b0;
        mem.i_memAddress  = '0;
        mem.i_memData     = '0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        total++;
        if ({mem.o_ready, mem.o_busy, mem.o_error, mem.o_halted, mem.o_dumpValid} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 00000",
                     {mem.o_ready, mem.o_busy, mem.o_error, mem.o_halted, mem.o_dumpValid});
        end
        total++;
        if ({mem.o_readData, mem.o_dumpAddr, mem.o_dumpData} !== 96'd0) begin
            bad++;
            $display("FAIL reset_data: got %h %h %h want zeros", mem.o_readData, mem.o_dumpAddr, mem.o_dumpData);
        end
        @(negedge clock);
        reset = 1'b1;

        transact(1'b1, 32'h10, 32'h0, lat, err, rd);
        model_step(1'b1, 32'h10, 32'h0, e_err, e_rd);
        transact(1'b1, 32'h14, 32'hCAFE_F00D, lat, err, rd);
        model_step(1'b1, 32'h14, 32'hCAFE_F00D, e_err, e_rd);
        transact(1'b0, 32'h14, 32'h0, lat, err, rd);
        model_step(1'b0, 32'h14, 32'h0, e_err, e_rd);
        total++;
        if (rd !== e_rd) begin
            bad++;
            $display("FAIL pre_abort_read: got %h want %h", rd, e_rd);
        end

        // Abort a write mid-ACCESS with an asynchronous reset.
        @(negedge clock);
        mem.i_memoryWrite = 1'b1;
        mem.i_readOrWrite = 1'b1;
        mem.i_memAddress  = 32'h10;
        mem.i_memData     = 32'hDEAD_BEEF;
        @(posedge clock);
        #1;
        mem.i_readOrWrite = 1'b0;
        total++;
        if (mem.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_busy: got %b want 1", mem.o_busy);
        end
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        total++;
        if ({mem.o_ready, mem.o_busy, mem.o_error, mem.o_halted, mem.o_readData} !== 36'd0) begin
            bad++;
            $display("FAIL abort_outputs: got %b/%b/%b/%b %h want all zero",
                     mem.o_ready, mem.o_busy, mem.o_error, mem.o_halted, mem.o_readData);
        end
        model_rd = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        transact(1'b0, 32'h10, 32'h0, lat, err, rd);
        model_step(1'b0, 32'h10, 32'h0, e_err, e_rd);
        total++;
        if (rd !== 32'h0 || err !== 1'b0 || lat != RESP_LAT) begin
            bad++;
            $display("FAIL abort_readback: got rd=%h err=%b lat=%0d want rd=0 err=0 lat=%0d", rd, err, lat, RESP_LAT);
        end
    endtask

    task automatic test_basic;
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          e_err;
        logic [31:0] e_rd;
        transact(1'b1, 32'h40, 32'h1234_5678, lat, err, rd);
        model_step(1'b1, 32'h40, 32'h1234_5678, e_err, e_rd);
        total++;
        if (lat != RESP_LAT || err !== 1'b0 || rd !== e_rd) begin
            bad++;
            $display("FAIL basic_write: got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=%h", lat, err, rd, RESP_LAT, e_rd);
        end
        transact(1'b0, 32'h40, 32'h0, lat, err, rd);
        model_step(1'b0, 32'h40, 32'h0, e_err, e_rd);
        total++;
        if (lat != RESP_LAT) begin
            bad++;
            $display("FAIL basic_read_lat: got %0d want %0d", lat, RESP_LAT);
        end
        total++;
        if (rd !== 32'h1234_5678 || err !== 1'b0) begin
            bad++;
            $display("FAIL basic_read_data: got rd=%h err=%b want rd=12345678 err=0", rd, err);
        end
    endtask

    task automatic test_errors;
        bit          wr_t [9];
        logic [31:0] a_t  [9];
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          e_err;
        logic [31:0] e_rd;
        wr_t = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        a_t  = '{32'h42, 32'h1000, 32'h42, 32'h100, 32'hFFFF_FFFF, 32'h100, 32'h40, 32'hFC, 32'hFC};
        for (int k = 0; k < 9; k++) begin
            logic [31:0] d;
            d = 32'hA5A5_0000 | 32'(k);
            transact(wr_t[k], a_t[k], d, lat, err, rd);
            model_step(wr_t[k], a_t[k], d, e_err, e_rd);
            total++;
            if (lat != RESP_LAT || err !== e_err || rd !== e_rd) begin
                bad++;
                $display("FAIL err_case%0d: got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                         k, lat, err, rd, RESP_LAT, e_err, e_rd);
            end
        end
        total++;
        if (mem.o_halted !== 1'b0) begin
            bad++;
            $display("FAIL write_sentinel_halt: got %b want 0", mem.o_halted);
        end
    endtask

    task automatic test_random;
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          e_err;
        logic [31:0] e_rd;
        for (int n = 0; n < 40; n++) begin
            int          kind;
            int          i;
            bit          wr;
            logic [31:0] addr;
            logic [31:0] data;
            kind = int'($urandom_range(0, 9));
            i    = int'($urandom_range(0, DEPTH - 1));
            wr   = 1'($urandom_range(0, 1));
            data = $urandom;
            if (kind <= 5) begin
                addr = 32'(i) << 2;
                if (!wr && !known[i]) wr = 1'b1;
            end else if (kind <= 7) begin
                addr = (32'(i) << 2) | 32'($urandom_range(1, 3));
            end else begin
                addr = $urandom | (32'h1 << (AW + 2));
                if (addr == 32'hFFFF_FFFF) addr = 32'h8000_0000;
            end
            transact(wr, addr, data, lat, err, rd);
            model_step(wr, addr, data, e_err, e_rd);
            total++;
            if (lat != RESP_LAT || err !== e_err || rd !== e_rd) begin
                bad++;
                $display("FAIL rand%0d wr=%b addr=%h: got lat=%0d err=%b rd=%h want lat=%0d err=%b rd=%h",
                         n, wr, addr, lat, err, rd, RESP_LAT, e_err, e_rd);
            end
        end
    endtask

    task automatic test_back_to_back;
        int ready_at[$];
        int busy_low;
        int gap;
        busy_low = 0;
        @(negedge clock);
        mem.i_memoryWrite = 1'b0;
        mem.i_readOrWrite = 1'b1;
        mem.i_memAddress  = 32'h40;
        for (int e = 1; e <= 4 * (RESP_LAT + 1); e++) begin
            @(posedge clock);
            #1;
            if (mem.o_ready === 1'b1) begin
                ready_at.push_back(e);
                total++;
                if (mem.o_readData !== model_mem[16] || mem.o_error !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_data@%0d: got %h err=%b want %h err=0", e, mem.o_readData, mem.o_error, model_mem[16]);
                end
            end
            if (mem.o_busy === 1'b0 && ready_at.size() == 1) busy_low++;
        end
        @(negedge clock);
        mem.i_readOrWrite = 1'b0;
        model_rd = model_mem[16];
        gap = (ready_at.size() >= 2) ? ready_at[1] - ready_at[0] : -1;
        total++;
        if (ready_at.size() != 4) begin
            bad++;
            $display("FAIL b2b_count: got %0d want 4", ready_at.size());
        end
        total++;
        if (ready_at.size() < 1 || ready_at[0] != RESP_LAT) begin
            bad++;
            $display("FAIL b2b_first: got %0d want %0d", (ready_at.size() > 0) ? ready_at[0] : -1, RESP_LAT);
        end
        total++;
        if (gap != RESP_LAT + 1) begin
            bad++;
            $display("FAIL b2b_gap: got %0d want %0d", gap, RESP_LAT + 1);
        end
        total++;
        if (busy_low != 1) begin
            bad++;
            $display("FAIL b2b_busy_low: got %0d want 1", busy_low);
        end
        @(posedge clock);
        #1;
        total++;
        if (mem.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: got busy=%b want 0", mem.o_busy);
        end
    endtask

    task automatic test_fill;
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          e_err;
        logic [31:0] e_rd;
        int          fill_bad;
        fill_bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            transact(1'b1, 32'(i) << 2, 32'(i * 3), lat, err, rd);
            model_step(1'b1, 32'(i) << 2, 32'(i * 3), e_err, e_rd);
            if (lat != RESP_LAT || err !== 1'b0) fill_bad++;
        end
        total++;
        if (fill_bad != 0) begin
            bad++;
            $display("FAIL fill: got %0d bad writes want 0", fill_bad);
        end
    endtask

    task automatic test_halt;
        int          halt_at;
        int          beats;
        int          beat_edge_bad;
        int          dump_nonzero;
        int          ready_seen;
        int          lat;
        logic        err;
        logic [31:0] rd;
        bit          e_err;
        logic [31:0] e_rd;
        halt_at = -1;
        beats = 0;
        beat_edge_bad = 0;
        dump_nonzero = 0;
        ready_seen = 0;
        @(negedge clock);
        mem.i_memoryWrite = 1'b0;
        mem.i_readOrWrite = 1'b1;
        mem.i_memAddress  = 32'hFFFF_FFFF;
        for (int e = 1; e <= DEPTH + 6; e++) begin
            @(posedge clock);
            #1;
            mem.i_readOrWrite = 1'b0;
            if (mem.o_ready === 1'b1) ready_seen++;
            if (mem.o_dumpValid !== 1'b1 && (mem.o_dumpAddr !== 32'd0 || mem.o_dumpData !== 32'd0)) dump_nonzero++;
            if (mem.o_dumpValid === 1'b1) begin
                if (e != beats + 1) beat_edge_bad++;
                total++;
                if (mem.o_dumpAddr !== 32'(beats) << 2 || mem.o_dumpData !== model_mem[beats % DEPTH]) begin
                    bad++;
                    $display("FAIL dump_beat%0d: got addr=%h data=%h want addr=%h data=%h",
                             beats, mem.o_dumpAddr, mem.o_dumpData, 32'(beats) << 2, model_mem[beats % DEPTH]);
                end
                beats++;
            end
            if (mem.o_halted === 1'b1 && halt_at < 0) halt_at = e;
        end
`ifdef MEM_DUMP_EN
        total++;
        if (beats != DEPTH || beat_edge_bad != 0) begin
            bad++;
            $display("FAIL dump_beats: got %0d (gaps %0d) want %0d", beats, beat_edge_bad, DEPTH);
        end
        total++;
        if (halt_at != DEPTH + 1) begin
            bad++;
            $display("FAIL halt_edge: got %0d want %0d", halt_at, DEPTH + 1);
        end
`else
        total++;
        if (beats != 0 || dump_nonzero != 0) begin
            bad++;
            $display("FAIL dump_quiet: got beats=%0d nonzero=%0d want 0", beats, dump_nonzero);
        end
        total++;
        if (halt_at != 2) begin
            bad++;
            $display("FAIL halt_edge: got %0d want 2", halt_at);
        end
`endif
        // Requests after halt must be ignored.
        @(negedge clock);
        mem.i_memoryWrite = 1'b1;
        mem.i_readOrWrite = 1'b1;
        mem.i_memAddress  = 32'h40;
        mem.i_memData     = 32'h5555_5555;
        for (int e = 0; e < 10; e++) begin
            @(posedge clock);
            #1;
            if (mem.o_ready === 1'b1) ready_seen++;
        end
        total++;
        if (ready_seen != 0) begin
            bad++;
            $display("FAIL halt_no_ready: got %0d pulses want 0", ready_seen);
        end
        total++;
        if (mem.o_halted !== 1'b1 || mem.o_busy !== 1'b1) begin
            bad++;
            $display("FAIL halt_sticky: got halted=%b busy=%b want 1 1", mem.o_halted, mem.o_busy);
        end
        @(negedge clock);
        mem.i_readOrWrite = 1'b0;
        reset = 1'b0;
        #1;
        total++;
        if (mem.o_halted !== 1'b0 || mem.o_busy !== 1'b0) begin
            bad++;
            $display("FAIL halt_reset: got halted=%b busy=%b want 0 0", mem.o_halted, mem.o_busy);
        end
        model_rd = 32'd0;
        @(negedge clock);
        reset = 1'b1;
        transact(1'b0, 32'h40, 32'h0, lat, err, rd);
        model_step(1'b0, 32'h40, 32'h0, e_err, e_rd);
        total++;
        if (lat != RESP_LAT || err !== 1'b0 || rd !== e_rd) begin
            bad++;
            $display("FAIL post_halt_read: got lat=%0d err=%b rd=%h want lat=%0d err=0 rd=%h", lat, err, rd, RESP_LAT, e_rd);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_errors();
        test_random();
        test_back_to_back();
        test_fill();
        test_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
